// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of the data-memory load/store interface. Accepts one
//   request at a time over valid/ready, waits WAIT_CYCLES states, then
//   commits the access and returns a one-cycle response pulse. Stores are
//   byte-masked; loads return the full word. Misaligned or out-of-range
//   accesses return rsp_err=1 with zero data and never touch the array.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept this cycle (IDLE only)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables (ignored for loads)
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    misaligned / out-of-range flag, valid with rsp_valid
//   busy       a request is in flight
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              c_err;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit edge is the accept edge itself, so the
  // access must be taken straight from the request inputs rather than the
  // latched copy, which is only loaded on that same edge.
  assign enter_resp = (ZERO_WAIT && accept) || ((state == S_WAIT) && (cnt == 4'd0));

  always_comb begin
    c_we    = lat_we;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
  end

  assign word_idx = c_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign c_err    = (c_addr[1:0] != 2'b00) || (word_idx >= IDX_W'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CNT_INIT;
            state     <= ZERO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        rsp_err   <= c_err;
        rsp_rdata <= (!c_err && !c_we) ? mem[mem_idx] : '0;
      end else if (state == S_RESP) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Storage is never reset. The reset term blocks a zero-wait accept from
  // committing while reset is held (IDLE keeps req_ready high).
  always_ff @(posedge clk) begin
    if (reset && enter_resp && c_we && !c_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (c_be[i]) mem[mem_idx][i*8 +: 8] <= c_wdata[i*8 +: 8];
      end
    end
  end

endmodule
